apb_master_arbiter: RTL
=======================

# apb_master_arbiter

Round-robin arbiter and APB transfer sequencer that shares one APB bus (Pselx[3:0], Penable, Pwrite, Paddr, Pwdata, Prdata) between two requesters: port m0 (the AHB bridge write/read path) and port m1 (the configuration/debug path). It sits between the bridge front-end and the APB slaves. It decodes the slave select, runs the SETUP/ACCESS phases with no wait states, and returns read data, completion and error status to the granted requester.

## Interface
- BASE, 32'h8000_0000: APB window base. Only bits [31:26] are compared.
- Hclk  in  1  single clock; all logic on posedge.
- Hreset  in  1  reset; synchronous, active-high.
- m0_valid / m1_valid  in  1  request pending; must be held with its fields until the matching ready.
- m0_ready / m1_ready  out  1  combinational accept pulse, one cycle per accepted request.
- m0_write / m1_write  in  1  1 = write, 0 = read.
- m0_addr / m1_addr  in  32  byte address.
- m0_wdata / m1_wdata  in  32  write data.
- m0_done / m1_done  out  1  one-cycle completion pulse, registered.
- m0_rdata / m1_rdata  out  32  read data; valid only while done=1.
- m0_err / m1_err  out  1  decode error; valid only while done=1.
- Pselx  out  4  one-hot slave select.
- Penable  out  1  APB enable.
- Pwrite  out  1  APB direction.
- Paddr  out  32  APB address.
- Pwdata  out  32  APB write data.
- Prdata  in  32  APB read data.

## Operation
- The FSM has four states: IDLE, SETUP, ACCESS, ERROR. Reset state is IDLE.
- Arbitration runs only in IDLE and in ACCESS, its final cycle. These are the "accept slots."
- Arbitration rules:
  - If only one valid is high, that requester wins.
  - If both are high, the requester not granted last wins.
  - last_grant resets to 1, so m0 wins the first tie.
- Accept: the winner's ready=1 in the same cycle. Its write, addr and wdata are captured, and its id is recorded. last_grant is updated.
- Address decode:
  - in-window means addr[31:26] == BASE[31:26].
  - Slave index = addr[25:24]. Pselx = 4'b0001 << index.
  - Paddr = the full 32-bit address.
- Transitions:
  - IDLE: in-window accept goes to SETUP. Out-of-window accept goes to ERROR. With no valid, stay in IDLE.
  - SETUP goes to ACCESS unconditionally. There is no PREADY; every ACCESS is one cycle.
  - ACCESS follows the same accept rules as IDLE. With no accept, go to IDLE.
  - ERROR goes to IDLE. No bus activity occurs.
- Bus outputs:
  - SETUP: Pselx = decoded value, Penable=0.
  - ACCESS: Pselx unchanged, Penable=1.
  - IDLE and ERROR: Pselx=0, Penable=0.
  - Pwrite, Paddr and Pwdata are stable from SETUP through ACCESS. Outside a transfer they hold their last values.
- Completion:
  - Read: Prdata is registered at the end of ACCESS and appears on that requester's rdata.
  - Write: rdata=0.
  - done pulses one cycle after ACCESS, or one cycle after the ERROR cycle.
  - For an error completion: err=1 and rdata=0.
  - The non-granted requester's done, err and rdata stay 0.
- Reset values:
  - Pselx=0, Penable=0, Pwrite=0, Paddr=0, Pwdata=0.
  - All done, err and rdata outputs = 0.
  - State = IDLE, last_grant = 1.
  - ready=0 during any cycle with Hreset=1.
- Reset mid-transfer: the next edge forces reset values. The in-flight transfer is dropped with no done pulse. The requester must re-present it.
- Requesters may not withdraw valid before ready. Behaviour if they do is undefined.

## Timing
- Single request from IDLE, accepted at cycle T:
  - ready at T.
  - SETUP at T+1.
  - ACCESS at T+2; Prdata is sampled on the T+2→T+3 edge.
  - done and rdata at T+3.
- Back-to-back requests:
  - The next request is accepted in ACCESS at T+2 and enters SETUP at T+3.
  - Sustained throughput is one transfer per 2 cycles.
  - Pselx may change between consecutive transfers with no idle gap. Penable drops to 0 for the SETUP cycle.
- Error request accepted at T: ERROR at T+1, done+err at T+2, next accept slot at T+2 (IDLE).
- Simultaneous valids in the same slot: exactly one ready. The loser keeps valid asserted and wins the next slot.
- done for transfer N coincides with the SETUP cycle of transfer N+1.

## Test plan
- Reset: assert Hreset for 3 cycles mid-ACCESS. Required: Pselx=0, Penable=0, Paddr=0 and no done on the edge after reset. The first tie after release grants m0.
- m0 single read of 0x8200_0010 with Prdata=0xDEAD_BEEF. Required:
  - ready at T.
  - Pselx=4'b0100, Penable=0 at T+1.
  - Penable=1 at T+2.
  - m0_done=1, m0_rdata=0xDEAD_BEEF, m0_err=0 at T+3.
- m1 write of 0x8300_0004 with data 0x1234_5678. Required:
  - Pselx=4'b1000, Pwrite=1, Pwdata=0x1234_5678, held stable across SETUP and ACCESS.
  - m1_done with m1_rdata=0.
- Both valid continuously, 4 requests each. Required:
  - Grants alternate m0, m1, m0, ...
  - Transfers run back-to-back at 2 cycles each with no IDLE cycle.
  - 8 done pulses on the correct ports.
- m0 request to 0x4000_0000. Required: Pselx stays 0 throughout; m0_done=1, m0_err=1, m0_rdata=0 two cycles after ready.
- Error on m1 and valid read on m0 presented together. Required: completion order follows the round-robin grant order, and the error cycle produces no APB activity.

Source files
------------

// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter
// Shares one APB bus between two requesters (m0: bridge path, m1: config/debug
// path) with round-robin arbitration, decodes the slave select from the
// address, runs zero-wait-state SETUP/ACCESS phases and returns completion,
// read data and decode-error status to whichever requester was granted.
module apb_master_arbiter #(
  parameter logic [31:0] BASE = 32'h8000_0000
) (
  input  logic        Hclk,
  input  logic        Hreset,
  input  logic        m0_valid,
  output logic        m0_ready,
  input  logic        m0_write,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_done,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_valid,
  output logic        m1_ready,
  input  logic        m1_write,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_done,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic [3:0]  Pselx,
  output logic        Penable,
  output logic        Pwrite,
  output logic [31:0] Paddr,
  output logic [31:0] Pwdata,
  input  logic [31:0] Prdata
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_ERROR  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic        last_grant_q, last_grant_d;  // 1 = m1 was granted most recently
  logic        id_q, id_d;                  // requester owning the current transfer
  logic [3:0]  pselx_q, pselx_d;
  logic        penable_q, penable_d;
  logic        pwrite_q, pwrite_d;
  logic [31:0] paddr_q, paddr_d;
  logic [31:0] pwdata_q, pwdata_d;
  logic        m0_done_q, m0_done_d, m0_err_q, m0_err_d;
  logic        m1_done_q, m1_done_d, m1_err_q, m1_err_d;
  logic [31:0] m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;

  logic        slot_s;
  logic        accept_s;
  logic        win_s;
  logic        win_write_s;
  logic [31:0] win_addr_s;
  logic [31:0] win_wdata_s;
  logic        win_inwin_s;

  // One-hot slave select from the two slave-index address bits.
  function automatic logic [3:0] slave_decode(input logic [1:0] idx);
    slave_decode = 4'b0001 << idx;
  endfunction

  // Address falls inside the APB window when the top six bits match BASE.
  function automatic logic in_window(input logic [31:0] addr);
    in_window = (addr[31:26] == BASE[31:26]);
  endfunction

  // Arbitration: pick the winner of the current accept slot and raise its ready.
  always_comb begin
    slot_s      = 1'b0;
    win_s       = 1'b0;
    if (!Hreset && ((state_q == ST_IDLE) || (state_q == ST_ACCESS))) begin
      slot_s = 1'b1;
    end else begin
      slot_s = 1'b0;
    end
    if (m0_valid && m1_valid) begin
      win_s = ~last_grant_q;
    end else if (m1_valid) begin
      win_s = 1'b1;
    end else begin
      win_s = 1'b0;
    end
    accept_s    = slot_s && (m0_valid || m1_valid);
    m0_ready    = accept_s && !win_s;
    m1_ready    = accept_s && win_s;
    win_write_s = win_s ? m1_write : m0_write;
    win_addr_s  = win_s ? m1_addr  : m0_addr;
    win_wdata_s = win_s ? m1_wdata : m0_wdata;
    win_inwin_s = in_window(win_addr_s);
  end

  // State register with synchronous reset.
  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: accept slots branch to SETUP or ERROR, otherwise fall back to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_ACCESS: begin
        if (accept_s) begin
          state_d = win_inwin_s ? ST_SETUP : ST_ERROR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: state_d = ST_ACCESS;
      ST_ERROR: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output logic: next values of the bus, capture and completion registers.
  always_comb begin
    last_grant_d = last_grant_q;
    id_d         = id_q;
    pselx_d      = 4'b0000;
    penable_d    = 1'b0;
    pwrite_d     = pwrite_q;
    paddr_d      = paddr_q;
    pwdata_d     = pwdata_q;
    m0_done_d    = 1'b0;
    m0_err_d     = 1'b0;
    m0_rdata_d   = 32'h0000_0000;
    m1_done_d    = 1'b0;
    m1_err_d     = 1'b0;
    m1_rdata_d   = 32'h0000_0000;

    if (accept_s) begin
      id_d         = win_s;
      last_grant_d = win_s;
    end else begin
      id_d         = id_q;
      last_grant_d = last_grant_q;
    end

    // Out-of-window requests leave the bus fields untouched: no APB activity.
    if (state_q == ST_SETUP) begin
      pselx_d   = pselx_q;
      penable_d = 1'b1;
    end else if (accept_s && win_inwin_s) begin
      pselx_d  = slave_decode(win_addr_s[25:24]);
      pwrite_d = win_write_s;
      paddr_d  = win_addr_s;
      pwdata_d = win_wdata_s;
    end else begin
      pselx_d   = 4'b0000;
      penable_d = 1'b0;
    end

    case (state_q)
      ST_ACCESS: begin
        if (id_q) begin
          m1_done_d  = 1'b1;
          m1_rdata_d = pwrite_q ? 32'h0000_0000 : Prdata;
        end else begin
          m0_done_d  = 1'b1;
          m0_rdata_d = pwrite_q ? 32'h0000_0000 : Prdata;
        end
      end
      ST_ERROR: begin
        if (id_q) begin
          m1_done_d = 1'b1;
          m1_err_d  = 1'b1;
        end else begin
          m0_done_d = 1'b1;
          m0_err_d  = 1'b1;
        end
      end
      default: begin
        m0_done_d = 1'b0;
        m1_done_d = 1'b0;
      end
    endcase
  end

  // Registered outputs and captured request fields; reset drops any in-flight transfer.
  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      pselx_q      <= 4'b0000;
      penable_q    <= 1'b0;
      pwrite_q     <= 1'b0;
      paddr_q      <= 32'h0000_0000;
      pwdata_q     <= 32'h0000_0000;
      m0_done_q    <= 1'b0;
      m0_err_q     <= 1'b0;
      m0_rdata_q   <= 32'h0000_0000;
      m1_done_q    <= 1'b0;
      m1_err_q     <= 1'b0;
      m1_rdata_q   <= 32'h0000_0000;
    end else begin
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      pselx_q      <= pselx_d;
      penable_q    <= penable_d;
      pwrite_q     <= pwrite_d;
      paddr_q      <= paddr_d;
      pwdata_q     <= pwdata_d;
      m0_done_q    <= m0_done_d;
      m0_err_q     <= m0_err_d;
      m0_rdata_q   <= m0_rdata_d;
      m1_done_q    <= m1_done_d;
      m1_err_q     <= m1_err_d;
      m1_rdata_q   <= m1_rdata_d;
    end
  end

  assign Pselx    = pselx_q;
  assign Penable  = penable_q;
  assign Pwrite   = pwrite_q;
  assign Paddr    = paddr_q;
  assign Pwdata   = pwdata_q;
  assign m0_done  = m0_done_q;
  assign m0_err   = m0_err_q;
  assign m0_rdata = m0_rdata_q;
  assign m1_done  = m1_done_q;
  assign m1_err   = m1_err_q;
  assign m1_rdata = m1_rdata_q;

endmodule
